// File: rtl/audio_peak_meter.sv
// Windowed peak-magnitude and clip-count meter feeding the 8-digit hex display word.
// Two-stage pipeline: |sample| register, then window accumulate; data_out and window_done lag the window's last sample by one edge; no backpressure.
module audio_peak_meter #(
  parameter int                DATA_W     = 24,
  parameter int                WINDOW     = 48000,
  parameter logic [DATA_W-1:0] CLIP_LEVEL = 24'h7F0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              freeze,
  output logic [31:0]       data_out,
  output logic              window_done
);

  localparam int                CNT_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WINDOW - 1);

  logic [DATA_W-1:0] mag_q, mag_d;
  logic              v1_q;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [7:0]        clip_q, clip_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [31:0]       data_q, data_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] peak_f;
  logic [7:0]        clip_f;
  logic              is_clip;
  logic              last;

  // Most-negative input has no positive twin; pin it to full scale.
  always_comb begin
    mag_d = sample_in;
    if (sample_in[DATA_W-1]) begin
      mag_d = (sample_in == NEG_MIN) ? MAG_MAX : -sample_in;
    end
  end

  always_comb begin
    is_clip = (mag_q >= CLIP_LEVEL);
    peak_f  = (mag_q > peak_q) ? mag_q : peak_q;
    clip_f  = (is_clip && (clip_q != 8'hFF)) ? clip_q + 8'd1 : clip_q;
    last    = v1_q && (win_cnt_q == LAST_IDX);

    peak_d    = peak_q;
    clip_d    = clip_q;
    win_cnt_d = win_cnt_q;
    data_d    = data_q;
    done_d    = last;

    if (v1_q) begin
      if (last) begin
        // Closing sample is folded into the published result, then state restarts.
        peak_d    = '0;
        clip_d    = '0;
        win_cnt_d = '0;
        if (!freeze) begin
          data_d = {clip_f, peak_f};
        end
      end else begin
        peak_d    = peak_f;
        clip_d    = clip_f;
        win_cnt_d = win_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag_q     <= '0;
      v1_q      <= 1'b0;
      peak_q    <= '0;
      clip_q    <= '0;
      win_cnt_q <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      mag_q     <= sample_valid ? mag_d : mag_q;
      v1_q      <= sample_valid;
      peak_q    <= peak_d;
      clip_q    <= clip_d;
      win_cnt_q <= win_cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign data_out    = data_q;
  assign window_done = done_q;

endmodule
